pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that replaces the fixed per-stage latches between IF/ID/EX/MEM/WB. It carries an opaque WIDTH-bit payload under a valid/ready handshake, with separate stall (hold) and flush (bubble) behaviour. An optional skid entry keeps the upstream ready signal registered. It also provides a zero-payload guarantee for bubbles and a saturating stall-cycle counter for performance profiling.

---
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_reg.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready payload buffer with flush-to-bubble and a stall-cycle counter.
// One cycle in-to-out; SKID=1 absorbs one in-flight beat and keeps in_ready registered, SKID=0 passes out_ready through.
module pipe_stage_reg #(
  parameter int WIDTH = 128,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [1:0]       o_occupancy,
  output logic [15:0]      o_stall_cnt
);

  logic             r_m_v;
  logic             r_s_v;
  logic [WIDTH-1:0] r_m_d;
  logic [WIDTH-1:0] r_s_d;
  logic [15:0]      r_stall_cnt;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_m_v_nxt;
  logic             w_s_v_nxt;
  logic [WIDTH-1:0] w_m_d_nxt;
  logic [WIDTH-1:0] w_s_d_nxt;

  assign o_in_ready  = (SKID != 0) ? ~r_s_v : (~r_m_v | i_out_ready);
  assign w_in_fire   = i_in_valid & o_in_ready;
  assign w_out_fire  = r_m_v & i_out_ready;
  assign o_out_valid = r_m_v;
  assign o_out_data  = r_m_d;
  assign o_occupancy = {1'b0, r_m_v} + {1'b0, r_s_v};
  assign o_stall_cnt = r_stall_cnt;

  // Every path that empties an entry also zeroes its payload so bubbles read as nops.
  always_comb begin
    w_m_v_nxt = r_m_v;
    w_m_d_nxt = r_m_d;
    w_s_v_nxt = r_s_v;
    w_s_d_nxt = r_s_d;
    if (SKID == 0) begin
      w_s_v_nxt = 1'b0;
      w_s_d_nxt = '0;
      if (w_in_fire) begin
        w_m_v_nxt = 1'b1;
        w_m_d_nxt = i_in_data;
      end else if (w_out_fire) begin
        w_m_v_nxt = 1'b0;
        w_m_d_nxt = '0;
      end
    end else if (!r_m_v || w_out_fire) begin
      if (r_s_v) begin
        w_m_v_nxt = 1'b1;
        w_m_d_nxt = r_s_d;
        w_s_v_nxt = 1'b0;
        w_s_d_nxt = '0;
        if (w_in_fire) begin
          w_s_v_nxt = 1'b1;
          w_s_d_nxt = i_in_data;
        end
      end else if (w_in_fire) begin
        w_m_v_nxt = 1'b1;
        w_m_d_nxt = i_in_data;
      end else begin
        w_m_v_nxt = 1'b0;
        w_m_d_nxt = '0;
      end
    end else if (w_in_fire) begin
      w_s_v_nxt = 1'b1;
      w_s_d_nxt = i_in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_m_v <= 1'b0;
      r_m_d <= '0;
      r_s_v <= 1'b0;
      r_s_d <= '0;
    end else begin
      r_m_v <= w_m_v_nxt;
      r_m_d <= w_m_d_nxt;
      r_s_v <= w_s_v_nxt;
      r_s_d <= w_s_d_nxt;
    end
  end

  // Profiling counter survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_m_v && !i_out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1/WIDTH=128 and SKID=0/WIDTH=8 instances against queue-based models.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [127:0] a_in_data, a_out_data;
  logic [1:0]   a_occ;
  logic [15:0]  a_stall;

  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]   b_in_data, b_out_data;
  logic [1:0]   b_occ;
  logic [15:0]  b_stall;

  pipe_stage_reg #(.WIDTH(128), .SKID(1)) u_a (
    .clk(clk), .rst(rst), .i_flush(a_flush),
    .i_in_valid(a_in_valid), .o_in_ready(a_in_ready), .i_in_data(a_in_data),
    .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_out_data(a_out_data),
    .o_occupancy(a_occ), .o_stall_cnt(a_stall)
  );

  pipe_stage_reg #(.WIDTH(8), .SKID(0)) u_b (
    .clk(clk), .rst(rst), .i_flush(b_flush),
    .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
    .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_data(b_out_data),
    .o_occupancy(b_occ), .o_stall_cnt(b_stall)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference: each stage is just an ordered queue with a capacity and a stall tally.
  logic [127:0] aq[$];
  logic [7:0]   bq[$];
  logic [15:0]  a_st = '0;
  logic [15:0]  b_st = '0;
  int           an, bn;
  logic [127:0] a_exp_d;
  logic [7:0]   b_exp_d;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      an = aq.size();
      a_exp_d = (an != 0) ? aq[0] : '0;
      chk("a_in_ready", a_in_ready, an < 2);
      chk("a_out_valid", a_out_valid, an != 0);
      chk("a_out_data", a_out_data, a_exp_d);
      chk("a_occupancy", a_occ, an);
      chk("a_stall_cnt", a_stall, a_st);

      bn = bq.size();
      b_exp_d = (bn != 0) ? bq[0] : '0;
      chk("b_in_ready", b_in_ready, (bn == 0) || b_out_ready);
      chk("b_out_valid", b_out_valid, bn != 0);
      chk("b_out_data", b_out_data, b_exp_d);
      chk("b_occupancy", b_occ, bn);
      chk("b_stall_cnt", b_stall, b_st);

      if (rst) begin
        aq.delete();
        bq.delete();
        a_st = '0;
        b_st = '0;
      end else begin
        if (an != 0 && !a_out_ready && a_st != 16'hFFFF) a_st = a_st + 16'd1;
        if (a_flush) aq.delete();
        else begin
          if (an != 0 && a_out_ready) void'(aq.pop_front());
          if (a_in_valid && an < 2) aq.push_back(a_in_data);
        end
        if (bn != 0 && !b_out_ready && b_st != 16'hFFFF) b_st = b_st + 16'd1;
        if (b_flush) bq.delete();
        else begin
          if (bn != 0 && b_out_ready) void'(bq.pop_front());
          if (b_in_valid && (bn == 0 || b_out_ready)) bq.push_back(b_in_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    chk("rst_a_out_valid", a_out_valid, 1'b0);
    chk("rst_a_out_data", a_out_data, 128'h0);
    chk("rst_a_occ", a_occ, 2'd0);
    chk("rst_a_stall", a_stall, 16'h0);
    chk("rst_a_in_ready", a_in_ready, 1'b1);
    chk("rst_b_in_ready", b_in_ready, 1'b1);

    // Streaming at full rate
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data = 128'(i);
      tick();
      chk("stream_valid", a_out_valid, 1'b1);
      chk("stream_data", a_out_data, 128'(i));
    end
    a_in_valid = 1'b0;
    tick();
    chk("stream_drained", a_out_valid, 1'b0);
    chk("stream_stall", a_stall, 16'h0);

    // Backpressure into the skid entry
    a_in_valid = 1'b1; a_in_data = 128'hA;
    tick();
    a_out_ready = 1'b0; a_in_data = 128'hB;
    tick();
    chk("bp_in_ready_low", a_in_ready, 1'b0);
    chk("bp_occ", a_occ, 2'd2);
    a_in_data = 128'hC;
    tick();
    tick();
    chk("bp_stall3", a_stall, 16'd3);
    chk("bp_hold_a", a_out_data, 128'hA);
    chk("bp_occ_full", a_occ, 2'd2);
    chk("bp_model_occ", aq.size(), 2);
    chk("bp_model_head", aq[0], 128'hA);
    a_out_ready = 1'b1;
    tick();
    chk("bp_deliver_b", a_out_data, 128'hB);
    chk("bp_in_ready_back", a_in_ready, 1'b1);
    chk("bp_occ_one", a_occ, 2'd1);
    tick();
    chk("bp_deliver_c", a_out_data, 128'hC);
    a_in_valid = 1'b0;
    tick();
    chk("bp_empty", a_out_valid, 1'b0);

    // Flush with both entries held
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 128'h21;
    tick();
    a_in_data = 128'h22;
    tick();
    chk("fl_occ2", a_occ, 2'd2);
    a_flush = 1'b1; a_in_data = 128'h55;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("fl_valid", a_out_valid, 1'b0);
    chk("fl_data", a_out_data, 128'h0);
    chk("fl_occ0", a_occ, 2'd0);
    a_out_ready = 1'b1;
    tick();
    chk("fl_no_55", a_out_valid, 1'b0);

    // Delivery in the flush cycle
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 128'h7;
    tick();
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_flush = 1'b1;
    #1;
    chk("fd_fire", a_out_valid & a_out_ready, 1'b1);
    chk("fd_data", a_out_data, 128'h7);
    tick();
    a_flush = 1'b0;
    chk("fd_empty", a_occ, 2'd0);

    // Flush on an empty stage discards the incoming beat
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 128'h33;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("fe_empty", a_out_valid, 1'b0);

    // SKID=0: combinational out_ready -> in_ready
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 8'h11;
    tick();
    chk("s0_head", b_out_data, 8'h11);
    b_in_data = 8'h22;
    #1;
    chk("s0_in_ready_low", b_in_ready, 1'b0);
    b_out_ready = 1'b1;
    #1;
    chk("s0_in_ready_comb", b_in_ready, 1'b1);
    tick();
    chk("s0_next", b_out_data, 8'h22);
    b_in_valid = 1'b0;
    tick();
    chk("s0_empty", b_out_valid, 1'b0);

    // Randomised traffic with occasional flush and one mid-stream reset
    for (int i = 0; i < 3000; i++) begin
      rst = (i == 1500);
      a_in_valid = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_flush = ($urandom_range(0, 19) == 0);
      a_in_data = {$urandom, $urandom, $urandom, $urandom};
      b_in_valid = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_flush = ($urandom_range(0, 19) == 0);
      b_in_data = 8'($urandom);
      tick();
    end
    rst = 1'b0;
    a_flush = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;

    // Stall counter saturation
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 128'h99;
    tick();
    a_in_valid = 1'b0;
    repeat (70000) tick();
    chk("sat_ffff", a_stall, 16'hFFFF);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    chk("sat_after_flush", a_stall, 16'hFFFF);
    chk("sat_flush_empty", a_out_valid, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sat_rst_clear", a_stall, 16'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
